mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single byte-lane main-memory port between the instruction-side cache (requester 0) and the data-side cache (requester 1).
- Grants one requester at a time and registers its address, write enable and write data.
- Drives the fixed-latency memory for the configured number of cycles, then returns read data with a one-cycle done pulse.
- Sits between both caches' memory-side ports and the memory model.

Parameters:
- RD_LAT, 4: cycles the memory needs from address presentation to valid mem_data_out.
- WR_LAT, 5: cycles mem_write_en/address/data must be held for a memory write to complete.
- CNT_W, 4: width of the latency counter. Must satisfy 2**CNT_W > max(RD_LAT, WR_LAT).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  level request; held until the matching done.
- we0, we1  input  1 each  1 = write-back, 0 = refill read.
- addr0, addr1  input  32 each  word address.
- wdata0, wdata1  input  32 each  write data; byte 0 = [31:24].
- rdata  output  32  read data for the granted requester; byte 0 = [31:24].
- done0, done1  output  1 each  one-cycle completion pulse.
- gnt  output  2  one-hot current owner; 00 when idle.
- mem_addr  output  32  address to memory.
- mem_data_in  output  32  write bytes to memory; [31:24] = byte lane 0.
- mem_write_en  output  1  memory write strobe.
- mem_data_out  input  32  read bytes from memory; [31:24] = byte lane 0.

Behaviour:
- Reset (async, reset=0): state IDLE, cnt=0, last=1, and all outputs 0 (gnt, done0, done1, rdata, mem_addr, mem_data_in, mem_write_en).
- Reset mid-BUSY aborts the access. No done is issued, and mem_write_en drops immediately.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no requests: stay in IDLE.
- IDLE, any request:
  - Pick the winner. Round-robin: if both request, grant the one not equal to last; otherwise grant the only requester.
  - Register the winner's addr, we and wdata into mem_addr, mem_write_en and mem_data_in.
  - Set gnt one-hot, set last = winner, cnt=0, go to BUSY.
- BUSY:
  - cnt increments each cycle.
  - Outputs to memory are held constant.
  - Leave BUSY when cnt == LAT-1, where LAT = WR_LAT if we else RD_LAT.
  - On that edge: for a read, rdata <= mem_data_out; for a write, rdata is unchanged.
  - mem_write_en <= 0, go to DONE.
- DONE: done of the granted requester = 1 for exactly this cycle. Then gnt <= 0, go to IDLE.
- Request lines are ignored in BUSY and DONE.
- The requester must drop req in the cycle done is high. A req still high in the following IDLE cycle is a new request.
- Latency from req asserted in IDLE to done high:
  - read: RD_LAT+1 cycles (5 by default);
  - write: WR_LAT+1 cycles (6 by default).
- Back-to-back operation: the earliest next grant is the cycle after DONE, giving a minimum 1 idle cycle between accesses.
- Inputs change only at grant; address or data changes on the owner's lines during BUSY have no effect.
- rdata holds its last value until the next read completes.
- done0 and done1 are never high together; gnt is at most one-hot.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: requester 1 (data) always wins simultaneous requests; last is unused.
- Undefined: round-robin as above.
- Starvation of requester 0 under fixed priority is accepted and documented; it is not checked by assertions.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum arb_state_t {IDLE, BUSY, DONE};
  - constants REQ_IFETCH=0, REQ_DATA=1;
  - byte-lane order helper constants.
- One sub-module: arb_pick, combinational winner selection.
  - Inputs: req0, req1, last; the ARB_FIXED_PRIO_EN macro.
  - Output: one-hot grant.
  - Keeps the policy swappable and unit-testable.

Test Plan:
- Single read: req1=1, we1=0, addr1=0x0000_2004, memory returns 0xDEADBEEF -> mem_write_en stays 0, done1 rises in cycle 5, rdata=0xDEADBEEF, gnt=10 during cycles 1-5.
- Single write: req0=1, we0=1, addr0=0x40, wdata0=0x11223344 -> mem_write_en=1 for exactly 5 cycles, mem_data_in[31:24]=0x11, done0 in cycle 6, rdata unchanged.
- Contention, round-robin: req0 and req1 both held from reset -> grant order 0,1,0,1. Each done is followed by a grant of the other requester after 1 idle cycle.
- Contention with ARB_FIXED_PRIO_EN: both requests repeatedly -> requester 1 granted every time; requester 0 granted only once req1 drops.
- Reset mid-write: assert reset=0 at BUSY cnt=2 -> mem_write_en, gnt and done drop asynchronously. After release, a pending req0 is re-granted from IDLE.
- Address change during BUSY: change addr1 from 0x100 to 0x200 at cycle 2 -> mem_addr stays 0x100 through DONE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Byte lane 0 is the most significant byte of every 32-bit word.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DATA   = 1;

    localparam int BYTE0_MSB = 31;
    localparam int BYTE0_LSB = 24;
    localparam int BYTE3_MSB = 7;
    localparam int BYTE3_LSB = 0;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// Round-robin by default; ARB_FIXED_PRIO_EN makes the data side always win.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        gnt_o = 2'b00;
        if (req1_i) begin
            gnt_o[REQ_DATA] = 1'b1;
        end else if (req0_i) begin
            gnt_o[REQ_IFETCH] = 1'b1;
        end
    end
`else
    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            if (last_i) begin
                gnt_o[REQ_IFETCH] = 1'b1;
            end else begin
                gnt_o[REQ_DATA] = 1'b1;
            end
        end else if (req1_i) begin
            gnt_o[REQ_DATA] = 1'b1;
        end else if (req0_i) begin
            gnt_o[REQ_IFETCH] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between instruction and data caches.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed data-side priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 5,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata,
    output logic        done0,
    output logic        done1,
    output logic [1:0]  gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_write_en,
    input  logic [31:0] mem_data_out
);

    localparam logic [CNT_W-1:0] RD_END = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_END = CNT_W'(WR_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic [1:0]        gnt_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_data_in_q;
    logic              mem_we_q;
    logic [1:0]        pick;
    logic              any_req;
    logic              at_end;

    arb_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    assign any_req = req0 | req1;
    // mem_we_q stays set for the whole BUSY phase, so it also tells the op type.
    assign at_end  = (cnt_q == (mem_we_q ? WR_END : RD_END));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (at_end)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            last_q        <= 1'b1;
            gnt_q         <= 2'b00;
            rdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q         <= pick;
                        last_q        <= pick[REQ_DATA];
                        cnt_q         <= '0;
                        mem_addr_q    <= pick[REQ_DATA] ? addr1  : addr0;
                        mem_data_in_q <= pick[REQ_DATA] ? wdata1 : wdata0;
                        mem_we_q      <= pick[REQ_DATA] ? we1    : we0;
                    end
                end
                BUSY: begin
                    if (at_end) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_data_out;
                        end
                        mem_we_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    gnt_q <= 2'b00;
                end
                default: begin
                    gnt_q    <= 2'b00;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        done0 = 1'b0;
        done1 = 1'b0;
        if (state_q == DONE) begin
            done0 = gnt_q[REQ_IFETCH];
            done1 = gnt_q[REQ_DATA];
        end
    end

    assign gnt          = gnt_q;
    assign rdata        = rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_in_q;
    assign mem_write_en = mem_we_q;

endmodule
